// File: rtl/operand_entry_pkg.sv
// Shared constants, state encoding and echo helper for the operand_entry keypad front end.
//   Key codes : 0-9 digits, KEY_MINUS, KEY_ENTER, KEY_CLEAR (4'hD-F unused).
//   Digits    : DIGIT_BLANK / DIGIT_MINUS / DIGIT_ERR glyph codes for the echo display.
package operand_entry_pkg;

  localparam int unsigned KEY_W = 4;
  localparam int unsigned MAG_W = 4;
  localparam int unsigned ACC_W = 8;
  localparam int unsigned SUM_W = 12;

  localparam logic [KEY_W-1:0] KEY_DIGIT_MAX = 4'h9;
  localparam logic [KEY_W-1:0] KEY_MINUS     = 4'hA;
  localparam logic [KEY_W-1:0] KEY_ENTER     = 4'hB;
  localparam logic [KEY_W-1:0] KEY_CLEAR     = 4'hC;

  localparam logic [ACC_W-1:0] MAX_MAG = 8'd15;

  localparam logic [3:0] DIGIT_BLANK = 4'hF;
  localparam logic [3:0] DIGIT_MINUS = 4'hA;
  localparam logic [3:0] DIGIT_ERR   = 4'hE;

  typedef enum logic [1:0] {
    ENTER_X = 2'd0,
    ENTER_Y = 2'd1,
    DONE    = 2'd2,
    ERROR   = 2'd3
  } entryState_t;

  // Split a 0-15 magnitude into {tens, ones} with a blanked leading zero.
  function automatic logic [7:0] echoPair(input logic [MAG_W-1:0] mag);
    if (mag >= 4'd10) begin
      return {4'd1, 4'(mag - 4'd10)};
    end
    return {DIGIT_BLANK, mag};
  endfunction

endpackage

// File: rtl/operand_entry_accumulator.sv
// decimal_accumulator: 8-bit decimal accumulator, acc <= acc*10 + digit.
//   clk, rst_n     : clock, async active-low reset (acc -> 0)
//   clr            : synchronous clear, wins over digitEn
//   digitEn, digit : append one decimal digit
//   acc            : registered accumulator value
//   overflow_c     : acc*10 + digit would exceed MAX_MAG
module decimal_accumulator
  import operand_entry_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             digitEn,
  input  logic [KEY_W-1:0] digit,
  output logic [ACC_W-1:0] acc,
  output logic             overflow_c
);

  logic [SUM_W-1:0] sum;
  logic [ACC_W-1:0] accNext;

  // Wide enough that a stored value up to 159 cannot wrap during the compare.
  assign sum        = SUM_W'(acc) * SUM_W'(10) + SUM_W'(digit);
  assign overflow_c = sum > SUM_W'(MAX_MAG);

  always_comb begin
    accNext = acc;
    if (clr) begin
      accNext = '0;
    end else if (digitEn) begin
      accNext = ACC_W'(sum);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else begin
      acc <= accNext;
    end
  end

endmodule

// File: rtl/operand_entry.sv
// operand_entry: keypad front end that accumulates sign-magnitude operands X then Y
// in decimal and presents them with a valid/ready handshake.
//   clk, rst_n           : clock, async active-low reset
//   key_valid, key_code  : one key per cycle, always accepted
//   op_valid, op_ready   : operand pair handshake
//   signX/operandX, signY/operandY : captured operands (1 = negative)
//   err                  : magnitude overflow during the current entry
//   d1..d6               : echo digits, present only when OPERAND_ENTRY_ECHO_EN is defined
module operand_entry
  import operand_entry_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic [KEY_W-1:0] key_code,
  output logic             op_valid,
  input  logic             op_ready,
  output logic             signX,
  output logic             signY,
  output logic [MAG_W-1:0] operandX,
  output logic [MAG_W-1:0] operandY,
  output logic             err
`ifdef OPERAND_ENTRY_ECHO_EN
  ,
  output logic [3:0]       d1,
  output logic [3:0]       d2,
  output logic [3:0]       d3,
  output logic [3:0]       d4,
  output logic [3:0]       d5,
  output logic [3:0]       d6
`endif
);

  entryState_t      state, stateNext;
  logic             pendSign, pendSignNext;
  logic             signXNext, signYNext;
  logic [MAG_W-1:0] operandXNext, operandYNext;
  logic             opValidNext, errNext;
  logic             accClr, accLoad;
  logic [ACC_W-1:0] acc;
  logic             overflow_c;
  logic             capSign;
  logic [MAG_W-1:0] capMag;

  decimal_accumulator uAcc (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (accClr),
    .digitEn    (accLoad),
    .digit      (key_code),
    .acc        (acc),
    .overflow_c (overflow_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ENTER_X;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    stateNext    = state;
    pendSignNext = pendSign;
    signXNext    = signX;
    signYNext    = signY;
    operandXNext = operandX;
    operandYNext = operandY;
    opValidNext  = op_valid;
    errNext      = err;
    accClr       = 1'b0;
    accLoad      = 1'b0;
    // A zero magnitude is always captured as positive.
    capSign      = pendSign && (acc != '0);
    capMag       = MAG_W'(acc);

    if (key_valid && (key_code == KEY_CLEAR)) begin
      stateNext    = ENTER_X;
      pendSignNext = 1'b0;
      opValidNext  = 1'b0;
      errNext      = 1'b0;
      accClr       = 1'b1;
    end else begin
      unique case (state)
        ENTER_X, ENTER_Y: begin
          if (key_valid) begin
            if (key_code <= KEY_DIGIT_MAX) begin
              accLoad = 1'b1;
              if (overflow_c) begin
                stateNext = ERROR;
                errNext   = 1'b1;
              end
            end else if (key_code == KEY_MINUS) begin
              pendSignNext = ~pendSign;
            end else if (key_code == KEY_ENTER) begin
              accClr       = 1'b1;
              pendSignNext = 1'b0;
              if (state == ENTER_X) begin
                signXNext    = capSign;
                operandXNext = capMag;
                stateNext    = ENTER_Y;
              end else begin
                signYNext    = capSign;
                operandYNext = capMag;
                opValidNext  = 1'b1;
                stateNext    = DONE;
              end
            end
          end
        end
        DONE: begin
          // Keys other than clear are dropped, including one arriving with op_ready.
          if (op_ready) begin
            opValidNext = 1'b0;
            stateNext   = ENTER_X;
          end
        end
        ERROR: begin
          stateNext = ERROR;
        end
        default: begin
          stateNext = ENTER_X;
        end
      endcase
    end
  end

  // Registered operand and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pendSign <= 1'b0;
      signX    <= 1'b0;
      signY    <= 1'b0;
      operandX <= '0;
      operandY <= '0;
      op_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      pendSign <= pendSignNext;
      signX    <= signXNext;
      signY    <= signYNext;
      operandX <= operandXNext;
      operandY <= operandYNext;
      op_valid <= opValidNext;
      err      <= errNext;
    end
  end

`ifdef OPERAND_ENTRY_ECHO_EN
  logic [MAG_W-1:0] liveMag;
  logic             showSignX, showSignY;
  logic [MAG_W-1:0] showMagX, showMagY;
  logic [7:0]       pairX, pairY;
  logic [3:0]       d1Next, d2Next, d3Next, d4Next, d5Next, d6Next;

  // Post-edge accumulator value. A digit that does not overflow can only follow
  // acc 0 or 1, so the live value is either the digit or ten plus the digit.
  always_comb begin
    liveMag = MAG_W'(acc);
    if (accClr) begin
      liveMag = '0;
    end else if (accLoad) begin
      liveMag = (acc == ACC_W'(1)) ? MAG_W'(4'd10 + key_code) : key_code;
    end
  end

  // Echo digits: live entry for the operand being keyed, captured value otherwise.
  always_comb begin
    showSignX = (stateNext == ENTER_X) ? pendSignNext : signXNext;
    showMagX  = (stateNext == ENTER_X) ? liveMag      : operandXNext;
    showSignY = (stateNext == ENTER_Y) ? pendSignNext : signYNext;
    showMagY  = (stateNext == ENTER_Y) ? liveMag      : operandYNext;
    pairX     = echoPair(showMagX);
    pairY     = echoPair(showMagY);
    d1Next    = showSignX ? DIGIT_MINUS : DIGIT_BLANK;
    d2Next    = pairX[7:4];
    d3Next    = pairX[3:0];
    d4Next    = showSignY ? DIGIT_MINUS : DIGIT_BLANK;
    d5Next    = pairY[7:4];
    d6Next    = pairY[3:0];
    if (stateNext == ERROR) begin
      d1Next = DIGIT_ERR;
      d2Next = DIGIT_ERR;
      d3Next = DIGIT_ERR;
      d4Next = DIGIT_ERR;
      d5Next = DIGIT_ERR;
      d6Next = DIGIT_ERR;
    end
  end

  // Echo digit registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1 <= DIGIT_BLANK;
      d2 <= DIGIT_BLANK;
      d3 <= DIGIT_BLANK;
      d4 <= DIGIT_BLANK;
      d5 <= DIGIT_BLANK;
      d6 <= DIGIT_BLANK;
    end else begin
      d1 <= d1Next;
      d2 <= d2Next;
      d3 <= d3Next;
      d4 <= d4Next;
      d5 <= d5Next;
      d6 <= d6Next;
    end
  end
`endif

endmodule

// File: tb/tb_operand_entry.sv
// Self-checking bench for operand_entry: directed key vectors with hand-computed
// operand/status expectations, plus DONE-hold, async-reset and echo sequences.
module tb_operand_entry;
  import operand_entry_pkg::*;

  localparam logic [3:0] K_MIN = 4'hA;
  localparam logic [3:0] K_ENT = 4'hB;
  localparam logic [3:0] K_CLR = 4'hC;

  logic       clk;
  logic       rst_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic       op_valid;
  logic       op_ready;
  logic       signX, signY;
  logic [3:0] operandX, operandY;
  logic       err;
`ifdef OPERAND_ENTRY_ECHO_EN
  logic [3:0] d1, d2, d3, d4, d5, d6;
`endif

  operand_entry dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .signX     (signX),
    .signY     (signY),
    .operandX  (operandX),
    .operandY  (operandY),
    .err       (err)
`ifdef OPERAND_ENTRY_ECHO_EN
    ,
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .d4        (d4),
    .d5        (d5),
    .d6        (d6)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {op_valid, err, signX, operandX, signY, operandY}
  logic [11:0] obs;
  assign obs = {op_valid, err, signX, operandX, signY, operandY};

  int nChecks = 0;
  int nFail   = 0;

  typedef struct {
    logic        kv;
    logic [3:0]  kc;
    logic        rdy;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [11:0] pk(input logic v, input logic e, input logic sx,
                                     input logic [3:0] ox, input logic sy,
                                     input logic [3:0] oy);
    return {v, e, sx, ox, sy, oy};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic addV(input logic kv, input logic [3:0] kc, input logic rdy,
                      input logic [11:0] exp);
    vecs.push_back('{kv: kv, kc: kc, rdy: rdy, exp: exp});
  endtask

  // Drive one cycle of inputs at the falling edge; return 1 time unit after the rising edge.
  task automatic step(input logic kv, input logic [3:0] kc, input logic rdy);
    @(negedge clk);
    key_valid = kv;
    key_code  = kc;
    op_ready  = rdy;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    op_ready  = 1'b0;
  endtask

  initial begin
    logic [3:0] kc;

    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    op_ready  = 1'b0;

    // Vector table: key, ready, expected outputs after the edge.
    addV(1, 4'd1, 0, pk(0,0,0,4'd0, 0,4'd0));
    addV(1, 4'd2, 0, pk(0,0,0,4'd0, 0,4'd0));
    addV(1, K_ENT, 0, pk(0,0,0,4'd12,0,4'd0));
    addV(1, K_MIN, 0, pk(0,0,0,4'd12,0,4'd0));
    addV(1, 4'd3, 0, pk(0,0,0,4'd12,0,4'd0));
    addV(1, K_ENT, 0, pk(1,0,0,4'd12,1,4'd3));
    addV(0, 4'd0, 1, pk(0,0,0,4'd12,1,4'd3));
    addV(1, K_MIN, 0, pk(0,0,0,4'd12,1,4'd3));
    addV(1, 4'd1, 0, pk(0,0,0,4'd12,1,4'd3));
    addV(1, 4'd5, 0, pk(0,0,0,4'd12,1,4'd3));
    addV(1, K_ENT, 0, pk(0,0,1,4'd15,1,4'd3));
    addV(1, K_ENT, 0, pk(1,0,1,4'd15,0,4'd0));
    addV(0, 4'd0, 1, pk(0,0,1,4'd15,0,4'd0));
    addV(1, K_MIN, 0, pk(0,0,1,4'd15,0,4'd0));
    addV(1, 4'd7, 0, pk(0,0,1,4'd15,0,4'd0));
    addV(1, K_ENT, 0, pk(0,0,1,4'd7, 0,4'd0));
    addV(1, K_MIN, 0, pk(0,0,1,4'd7, 0,4'd0));
    addV(1, K_ENT, 0, pk(1,0,1,4'd7, 0,4'd0));
    addV(0, 4'd0, 1, pk(0,0,1,4'd7, 0,4'd0));
    addV(1, 4'd1, 0, pk(0,0,1,4'd7, 0,4'd0));
    addV(1, 4'd6, 0, pk(0,1,1,4'd7, 0,4'd0));
    addV(1, K_ENT, 0, pk(0,1,1,4'd7, 0,4'd0));
    addV(1, 4'd2, 0, pk(0,1,1,4'd7, 0,4'd0));
    addV(1, K_CLR, 0, pk(0,0,1,4'd7, 0,4'd0));
    addV(1, 4'd1, 0, pk(0,0,1,4'd7, 0,4'd0));
    addV(1, 4'hD, 0, pk(0,0,1,4'd7, 0,4'd0));
    addV(1, 4'd1, 0, pk(0,0,1,4'd7, 0,4'd0));
    addV(1, K_ENT, 0, pk(0,0,0,4'd11,0,4'd0));
    addV(1, K_MIN, 0, pk(0,0,0,4'd11,0,4'd0));
    addV(1, 4'd9, 0, pk(0,0,0,4'd11,0,4'd0));
    addV(1, K_ENT, 0, pk(1,0,0,4'd11,1,4'd9));
    addV(1, K_CLR, 0, pk(0,0,0,4'd11,1,4'd9));
    addV(1, 4'd4, 0, pk(0,0,0,4'd11,1,4'd9));
    addV(1, K_ENT, 0, pk(0,0,0,4'd4, 1,4'd9));
    addV(1, 4'hF, 0, pk(0,0,0,4'd4, 1,4'd9));
    addV(1, K_ENT, 0, pk(1,0,0,4'd4, 0,4'd0));
    addV(1, 4'd8, 1, pk(0,0,0,4'd4, 0,4'd0));
    addV(1, K_ENT, 0, pk(0,0,0,4'd0, 0,4'd0));
    addV(1, 4'd3, 0, pk(0,0,0,4'd0, 0,4'd0));
    addV(1, K_ENT, 0, pk(1,0,0,4'd0, 0,4'd3));
    addV(1, K_CLR, 1, pk(0,0,0,4'd0, 0,4'd3));
    addV(1, 4'd2, 0, pk(0,0,0,4'd0, 0,4'd3));
    addV(1, K_MIN, 0, pk(0,0,0,4'd0, 0,4'd3));
    addV(1, K_ENT, 0, pk(0,0,1,4'd2, 0,4'd3));
    addV(1, K_CLR, 0, pk(0,0,1,4'd2, 0,4'd3));

    // Reset values.
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'(obs), 32'(pk(0,0,0,4'd0,0,4'd0)));
`ifdef OPERAND_ENTRY_ECHO_EN
    check("reset_echo", 32'({d1,d2,d3,d4,d5,d6}), 32'(24'hFFFFFF));
`endif
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].kv, vecs[i].kc, vecs[i].rdy);
      check($sformatf("vec%0d", i), 32'(obs), 32'(vecs[i].exp));
    end

    // DONE holds under keys while op_ready stays low.
    step(1, 4'd5, 0);
    step(1, K_ENT, 0);
    step(1, 4'd6, 0);
    step(1, K_ENT, 0);
    check("hold_enter", 32'(obs), 32'(pk(1,0,0,4'd5,0,4'd6)));
    for (int i = 0; i < 10; i++) begin
      kc = (i < 8) ? 4'(i) : ((i == 8) ? K_MIN : K_ENT);
      step(1, kc, 0);
      check($sformatf("hold%0d", i), 32'(obs), 32'(pk(1,0,0,4'd5,0,4'd6)));
    end
    step(0, 4'd0, 1);
    check("hold_release", 32'(obs), 32'(pk(0,0,0,4'd5,0,4'd6)));

    // Asynchronous reset mid-entry.
    step(1, 4'd7, 0);
    step(1, K_ENT, 0);
    step(1, 4'd4, 0);
    check("pre_reset", 32'(obs), 32'(pk(0,0,0,4'd7,0,4'd6)));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", 32'(obs), 32'(pk(0,0,0,4'd0,0,4'd0)));
`ifdef OPERAND_ENTRY_ECHO_EN
    check("async_reset_echo", 32'({d1,d2,d3,d4,d5,d6}), 32'(24'hFFFFFF));
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 4'd2, 0);
    step(1, K_ENT, 0);
    step(1, 4'd2, 0);
    step(1, K_ENT, 0);
    check("post_reset_pair", 32'(obs), 32'(pk(1,0,0,4'd2,0,4'd2)));
    step(0, 4'd0, 1);
    check("post_reset_ack", 32'(obs), 32'(pk(0,0,0,4'd2,0,4'd2)));

`ifdef OPERAND_ENTRY_ECHO_EN
    // Echo display: live entry, captured values, blanking and error fill.
    step(1, K_CLR, 0);
    step(1, K_MIN, 0);
    step(1, 4'd9, 0);
    check("echo_x_live", 32'({d1,d2,d3}), 32'(12'hAF9));
    check("echo_y_capt", 32'({d4,d5,d6}), 32'(12'hFF2));
    step(1, K_ENT, 0);
    check("echo_x_capt", 32'({d1,d2,d3}), 32'(12'hAF9));
    check("echo_y_zero", 32'({d4,d5,d6}), 32'(12'hFF0));
    step(1, 4'd1, 0);
    step(1, 4'd2, 0);
    check("echo_y_12", 32'({d4,d5,d6}), 32'(12'hF12));
    step(1, K_CLR, 0);
    check("echo_clear", 32'({d1,d2,d3,d4,d5,d6}), 32'(24'hFF0FF2));
    step(1, 4'd1, 0);
    step(1, 4'd6, 0);
    check("echo_err", 32'({d1,d2,d3,d4,d5,d6}), 32'(24'hEEEEEE));
    check("echo_err_flag", 32'(err), 32'(1'b1));
    step(1, K_CLR, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
